dm_port_arbiter: RTL and testbench
==================================

Name: dm_port_arbiter

Overview:
- Shares the single data-memory port between two requesters.
- Requester 0 is the pipeline MEM stage. Requester 1 is a secondary master, such as a debug or DMA engine.
- Registers the selected request, drives the DM strobes until the memory signals ready, then returns read data with a one-cycle done pulse.
- While requester 0 has a request that has not yet completed, the pipeline is stalled.

Parameters:
AW, 32, address width
DW, 32, data width
MAX_STARVE, 4, consecutive req0 grants allowed while req1 waits (used only with STARVE_GUARD_EN)

Ports:
CLK  in  1  clock
RESET  in  1  synchronous active-low reset, sampled on posedge CLK
req0_valid  in  1  MEM-stage request
req0_we  in  1  1=write, 0=read
req0_addr  in  AW  byte address
req0_wdata  in  DW  store data
req0_done  out  1  one-cycle completion pulse
req0_rdata  out  DW  read data, valid with req0_done
stall_MEM  out  1  freeze pipeline
req1_valid, req1_we, req1_addr, req1_wdata  in  1/1/AW/DW  secondary request
req1_done  out  1  completion pulse
req1_rdata  out  DW  read data
MemRead_2DM  out  1  DM read strobe
MemWrite_2DM  out  1  DM write strobe
data_address_2DM  out  AW  DM address
data_write_2DM  out  DW  DM write data
data_read_fDM  in  DW  DM read data
DM_ready_fDM  in  1  DM access complete this cycle

Behaviour:
- Reset (RESET==0 at posedge) → all outputs 0, state=IDLE, starve count=0. Reset mid-access abandons the access; no done pulse is issued.
- States: IDLE, BUSY0, BUSY1, DONE.
- IDLE arbitration:
  - req0_valid → BUSY0.
  - Else req1_valid → BUSY1.
  - Else stay in IDLE.
  - On the transition, latch we/addr/wdata of the winner into registers.
- BUSY0/BUSY1:
  - Registered strobes: MemRead_2DM = ~we, MemWrite_2DM = we.
  - Address and write data come from the latched registers and are stable for the whole access.
  - On DM_ready_fDM==1: capture data_read_fDM into the winner's rdata register, drop both strobes next cycle, go to DONE.
- DONE:
  - Pulse the winner's reqN_done for exactly 1 cycle.
  - reqN_rdata holds its value until that requester's next done. Write accesses leave rdata unchanged.
  - Next state is IDLE. No back-to-back grant from DONE.
- Minimum latency (valid at cycle N, in IDLE, DM ready on first strobe cycle):
  - Strobe at N+1.
  - Done at N+2.
  - Requester may deassert valid in the done cycle. A still-asserted valid after done is a new request.
- Requesters hold valid and payload stable until done. Payload changes mid-access are ignored, because the payload is latched.
- stall_MEM (combinational) = req0_valid & ~req0_done.
- Simultaneous req0/req1 in IDLE → req0 wins (base priority).
- Strobes are never both 1. Exactly one of req0_done/req1_done is high in the DONE state, never both.
- DM_ready_fDM is ignored outside BUSY0/BUSY1.

Optional Feature:
- Macro: STARVE_GUARD_EN.
- With the macro defined:
  - A 3-bit (clog2(MAX_STARVE)+1) counter increments on each req0 grant made while req1_valid=1.
  - The counter clears on any req1 grant, or when req1_valid=0.
  - When count==MAX_STARVE and req1_valid=1, the IDLE arbitration grants req1 even if req0_valid=1.
- Without the macro: strict req0 priority; req1 can starve indefinitely.

Test Plan:
- Reset then idle:
  - Hold RESET=0 for 2 cycles, then 1 with no requests.
  - Expect all strobes, done signals and stall_MEM = 0.
- req0 read:
  - Inputs: req0_valid=1, we=0, addr=0x100; DM ready on first strobe with data 0xDEADBEEF.
  - Expect MemRead_2DM at N+1, req0_done at N+2, req0_rdata=0xDEADBEEF.
  - Expect stall_MEM=1 at N and N+1, 0 at N+2.
- Slow write:
  - Inputs: req1 write, addr=0x40, wdata=0x12345678; DM_ready delayed 3 cycles.
  - Expect MemWrite_2DM high for 3 cycles with stable address/data.
  - Expect req1_done 1 cycle after ready; req1_rdata unchanged.
- Simultaneous requests:
  - Inputs: req0 and req1 valid in the same cycle.
  - Expect req0 served first; req1 granted in the IDLE following req0's DONE.
- Starvation guard:
  - Inputs: STARVE_GUARD_EN, MAX_STARVE=4, req0 continuously re-requesting, req1 held valid.
  - Expect exactly 4 req0 grants, then a req1 grant.
  - Without the macro, expect no req1 grant within 20 accesses.
- Reset mid-access:
  - Assert RESET=0 during BUSY0 with DM not ready.
  - Expect strobes at 0 next cycle, no done pulse, state IDLE after release.

Source files
------------

// File: rtl/dm_port_arbiter.sv
// Two-requester arbiter for the single data-memory port: requester 0 is the MEM stage, requester 1 a secondary master.
// Optional STARVE_GUARD_EN macro bounds how many req0 grants can pass while req1 is kept waiting.
module dm_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MAX_STARVE = 4
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          req0_valid,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_done,
  output logic [DW-1:0] req0_rdata,
  output logic          stall_MEM,
  input  logic          req1_valid,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          req1_done,
  output logic [DW-1:0] req1_rdata,
  output logic          MemRead_2DM,
  output logic          MemWrite_2DM,
  output logic [AW-1:0] data_address_2DM,
  output logic [DW-1:0] data_write_2DM,
  input  logic [DW-1:0] data_read_fDM,
  input  logic          DM_ready_fDM
);

  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1, DONE} state_t;

  state_t state, state_next;
  logic   grant0, grant1;
  logic   force1;
  logic   lat_we;
  logic   access_end;

`ifdef STARVE_GUARD_EN
  localparam int SW = $clog2(MAX_STARVE) + 1;
  logic [SW-1:0] starve_cnt;

  assign force1 = req1_valid && (starve_cnt == SW'(MAX_STARVE));

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      starve_cnt <= '0;
    end else if (!req1_valid || grant1) begin
      starve_cnt <= '0;
    end else if (grant0) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  // Strict priority; the comparison only keeps MAX_STARVE referenced in this build.
  assign force1 = (MAX_STARVE < 0);
`endif

  assign stall_MEM  = req0_valid & ~req0_done;
  assign access_end = ((state == BUSY0) || (state == BUSY1)) && DM_ready_fDM;

  always_comb begin
    state_next = state;
    grant0     = 1'b0;
    grant1     = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid && !force1) begin
          grant0     = 1'b1;
          state_next = BUSY0;
        end else if (req1_valid) begin
          grant1     = 1'b1;
          state_next = BUSY1;
        end
      end
      BUSY0, BUSY1: begin
        if (DM_ready_fDM) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state            <= IDLE;
      lat_we           <= 1'b0;
      data_address_2DM <= '0;
      data_write_2DM   <= '0;
      MemRead_2DM      <= 1'b0;
      MemWrite_2DM     <= 1'b0;
      req0_done        <= 1'b0;
      req1_done        <= 1'b0;
      req0_rdata       <= '0;
      req1_rdata       <= '0;
    end else begin
      state     <= state_next;
      req0_done <= 1'b0;
      req1_done <= 1'b0;
      // Winner's payload is latched so the DM sees a stable access even if the requester changes it.
      if (grant0) begin
        lat_we           <= req0_we;
        data_address_2DM <= req0_addr;
        data_write_2DM   <= req0_wdata;
        MemRead_2DM      <= ~req0_we;
        MemWrite_2DM     <= req0_we;
      end else if (grant1) begin
        lat_we           <= req1_we;
        data_address_2DM <= req1_addr;
        data_write_2DM   <= req1_wdata;
        MemRead_2DM      <= ~req1_we;
        MemWrite_2DM     <= req1_we;
      end else if (access_end) begin
        MemRead_2DM  <= 1'b0;
        MemWrite_2DM <= 1'b0;
        req0_done    <= (state == BUSY0);
        req1_done    <= (state == BUSY1);
        if (!lat_we) begin
          if (state == BUSY0) req0_rdata <= data_read_fDM;
          else                req1_rdata <= data_read_fDM;
        end
      end
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Scoreboard bench for dm_port_arbiter: drivers push expected completions, a negedge monitor pops and checks them.
`timescale 1ns/1ps
module tb_dm_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MAX_STARVE = 4;
`ifdef STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          req0_valid = 1'b0, req0_we = 1'b0;
  logic [AW-1:0] req0_addr = '0;
  logic [DW-1:0] req0_wdata = '0;
  logic          req1_valid = 1'b0, req1_we = 1'b0;
  logic [AW-1:0] req1_addr = '0;
  logic [DW-1:0] req1_wdata = '0;
  logic          req0_done, req1_done, stall_MEM;
  logic [DW-1:0] req0_rdata, req1_rdata;
  logic          MemRead_2DM, MemWrite_2DM;
  logic [AW-1:0] data_address_2DM;
  logic [DW-1:0] data_write_2DM;
  logic [DW-1:0] data_read_fDM = '0;
  logic          DM_ready_fDM = 1'b0;

  always #5 CLK = ~CLK;

  dm_port_arbiter #(.AW(AW), .DW(DW), .MAX_STARVE(MAX_STARVE)) dut (
    .CLK(CLK), .RESET(RESET),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_done(req0_done), .req0_rdata(req0_rdata), .stall_MEM(stall_MEM),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_done(req1_done), .req1_rdata(req1_rdata),
    .MemRead_2DM(MemRead_2DM), .MemWrite_2DM(MemWrite_2DM),
    .data_address_2DM(data_address_2DM), .data_write_2DM(data_write_2DM),
    .data_read_fDM(data_read_fDM), .DM_ready_fDM(DM_ready_fDM)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory contents: unwritten words hold a fixed address-derived pattern.
  bit [31:0] dm_mem  [bit [31:0]];
  bit [31:0] ref_mem [bit [31:0]];
  function automatic bit [31:0] seed_word(input bit [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  // DM model: ready after fixed_delay extra strobe cycles (random 0..3 when negative).
  int fixed_delay = -1;
  int dm_wait = 0;
  bit dm_busy = 1'b0;
  always @(negedge CLK) begin
    if (MemRead_2DM || MemWrite_2DM) begin
      if (!dm_busy) begin
        dm_busy = 1'b1;
        dm_wait = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
      end
      if (dm_wait == 0) begin
        DM_ready_fDM = 1'b1;
        if (MemWrite_2DM) begin
          if (RESET) dm_mem[data_address_2DM] = data_write_2DM;
          data_read_fDM = $urandom;
        end else begin
          data_read_fDM = dm_mem.exists(data_address_2DM) ? dm_mem[data_address_2DM]
                                                           : seed_word(data_address_2DM);
        end
      end else begin
        DM_ready_fDM = 1'b0;
        data_read_fDM = $urandom;
        dm_wait--;
      end
    end else begin
      dm_busy = 1'b0;
      DM_ready_fDM = 1'b0;
    end
  end

  // Reference: per-requester expected rdata at each completion.
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic [31:0] last_rd[2] = '{32'h0, 32'h0};

  function automatic void expect_access(input int p, input bit we, input bit [31:0] a, input bit [31:0] d);
    logic [31:0] v;
    if (we) begin
      ref_mem[a] = d;
      v = last_rd[p];
    end else begin
      v = ref_mem.exists(a) ? ref_mem[a] : seed_word(a);
      last_rd[p] = v;
    end
    if (p == 0) exp_q0.push_back(v);
    else        exp_q1.push_back(v);
  endfunction

  // Monitor state
  logic        p_strobe = 1'b0, p_we = 1'b0, prst = 1'b0;
  logic [31:0] p_addr = '0, p_wdata = '0;
  logic        pv1 = 1'b0, pwe0 = 1'b0, pwe1 = 1'b0;
  logic [31:0] pa0 = '0, pa1 = '0, pd0 = '0, pd1 = '0;
  int          pred = -1;
  int          sc = 0;
  int          grant_log[$];
  int          last_done0_cyc = 0, last_rise_cyc = 0;
  logic [31:0] hold0 = '0, hold1 = '0;
  logic        m_strobe, m_rose;

  always @(negedge CLK) begin
    m_strobe = MemRead_2DM | MemWrite_2DM;
    m_rose   = m_strobe & ~p_strobe;
    check("strobe_exclusive", MemRead_2DM & MemWrite_2DM, 1'b0);
    check("done_exclusive", req0_done & req1_done, 1'b0);
    check("stall_MEM", stall_MEM, req0_valid & ~req0_done);
    if (m_strobe && p_strobe) begin
      check("addr_stable", data_address_2DM, p_addr);
      check("we_stable", MemWrite_2DM, p_we);
      if (MemWrite_2DM) check("wdata_stable", data_write_2DM, p_wdata);
    end
    if (m_rose) begin
      if (pred < 0) begin
        check("spurious_grant", 1'b1, 1'b0);
      end else begin
        check("grant_addr", data_address_2DM, (pred == 0) ? pa0 : pa1);
        check("grant_we", MemWrite_2DM, (pred == 0) ? pwe0 : pwe1);
        if (MemWrite_2DM) check("grant_wdata", data_write_2DM, (pred == 0) ? pd0 : pd1);
        grant_log.push_back(pred);
        last_rise_cyc = cyc;
      end
    end
    if (!prst) begin
      hold0 = '0;
      hold1 = '0;
    end
    if (req0_done) begin
      if (exp_q0.size() == 0) check("req0_done_unexpected", 1'b1, 1'b0);
      else hold0 = exp_q0.pop_front();
      check("req0_rdata", req0_rdata, hold0);
      last_done0_cyc = cyc;
    end else begin
      check("req0_rdata_hold", req0_rdata, hold0);
    end
    if (req1_done) begin
      if (exp_q1.size() == 0) check("req1_done_unexpected", 1'b1, 1'b0);
      else hold1 = exp_q1.pop_front();
      check("req1_rdata", req1_rdata, hold1);
    end else begin
      check("req1_rdata_hold", req1_rdata, hold1);
    end
    // Starvation count: consecutive req0 grants taken while req1 was waiting.
    if (!prst || !pv1)          sc = 0;
    else if (m_rose && pred == 1) sc = 0;
    else if (m_rose && pred == 0) sc++;
    // Snapshot of what the arbiter will see at the coming edge.
    prst = RESET;
    pv1 = req1_valid;
    pwe0 = req0_we; pa0 = req0_addr; pd0 = req0_wdata;
    pwe1 = req1_we; pa1 = req1_addr; pd1 = req1_wdata;
    if (!RESET) pred = -1;
    else if (req0_valid && !(GUARD && sc == MAX_STARVE && req1_valid)) pred = 0;
    else if (req1_valid) pred = 1;
    else pred = -1;
    p_strobe = m_strobe; p_we = MemWrite_2DM;
    p_addr = data_address_2DM; p_wdata = data_write_2DM;
  end

  task automatic do_req(input int p, input bit we, input bit [31:0] a, input bit [31:0] d,
                        input bit hold_valid, input int budget);
    bit seen;
    seen = 1'b0;
    expect_access(p, we, a, d);
    @(posedge CLK); #1;
    if (p == 0) begin
      req0_valid = 1'b1; req0_we = we; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = 1'b1; req1_we = we; req1_addr = a; req1_wdata = d;
    end
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge CLK);
      seen = (p == 0) ? req0_done : req1_done;
    end
    check((p == 0) ? "req0_timeout" : "req1_timeout", seen, 1'b1);
    if (!hold_valid) begin
      @(posedge CLK); #1;
      if (p == 0) req0_valid = 1'b0;
      else        req1_valid = 1'b0;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, cnt;
    bit done_seen;

    // Reset, then idle
    repeat (2) begin
      @(negedge CLK);
      check("rst_memread", MemRead_2DM, 1'b0);
      check("rst_memwrite", MemWrite_2DM, 1'b0);
      check("rst_done0", req0_done, 1'b0);
      check("rst_done1", req1_done, 1'b0);
      check("rst_addr", data_address_2DM, '0);
      check("rst_wdata", data_write_2DM, '0);
      check("rst_rdata0", req0_rdata, '0);
      check("rst_rdata1", req1_rdata, '0);
    end
    @(posedge CLK); #1;
    RESET = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      check("idle_strobes", {MemRead_2DM, MemWrite_2DM}, 2'b00);
      check("idle_dones", {req0_done, req1_done}, 2'b00);
      check("idle_stall", stall_MEM, 1'b0);
    end

    // req0 read, minimum latency
    fixed_delay = 0;
    dm_mem[32'h100] = 32'hDEAD_BEEF;
    ref_mem[32'h100] = 32'hDEAD_BEEF;
    expect_access(0, 1'b0, 32'h100, 32'h0);
    @(posedge CLK); #1;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h100;
    @(negedge CLK);
    check("rd_N_stall", stall_MEM, 1'b1);
    check("rd_N_strobe", MemRead_2DM, 1'b0);
    @(negedge CLK);
    check("rd_N1_strobe", MemRead_2DM, 1'b1);
    check("rd_N1_stall", stall_MEM, 1'b1);
    check("rd_N1_addr", data_address_2DM, 32'h100);
    @(negedge CLK);
    check("rd_N2_done", req0_done, 1'b1);
    check("rd_N2_stall", stall_MEM, 1'b0);
    check("rd_N2_strobe", MemRead_2DM, 1'b0);
    check("rd_N2_rdata", req0_rdata, 32'hDEAD_BEEF);
    @(posedge CLK); #1;
    req0_valid = 1'b0;

    // Slow req1 write; payload changes mid-access must not reach the DM
    fixed_delay = 2;
    expect_access(1, 1'b1, 32'h40, 32'h1234_5678);
    @(posedge CLK); #1;
    req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 32'h40; req1_wdata = 32'h1234_5678;
    cnt = 0;
    done_seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (MemWrite_2DM) begin
        cnt++;
        check("wr_addr", data_address_2DM, 32'h40);
        check("wr_data", data_write_2DM, 32'h1234_5678);
        if (cnt == 1) begin
          @(posedge CLK); #1;
          req1_addr = 32'h44; req1_wdata = 32'hFFFF_0000;
        end
      end else if (cnt > 0) begin
        done_seen = req1_done;
        break;
      end
    end
    check("wr_strobe_cycles", cnt, 3);
    check("wr_done_after_ready", done_seen, 1'b1);
    check("wr_rdata_unchanged", req1_rdata, 32'h0);
    @(posedge CLK); #1;
    req1_valid = 1'b0;

    // Simultaneous requests: req0 first, req1 in the IDLE after req0's DONE
    fixed_delay = -1;
    n0 = grant_log.size();
    fork
      do_req(0, 1'b0, 32'h104, 32'h0, 1'b0, 60);
      do_req(1, 1'b0, 32'h40, 32'h0, 1'b0, 60);
    join
    check("simul_log_len", grant_log.size() >= n0 + 2, 1'b1);
    if (grant_log.size() >= n0 + 2) begin
      check("simul_first", grant_log[n0], 0);
      check("simul_second", grant_log[n0 + 1], 1);
    end
    check("simul_req1_gap", last_rise_cyc - last_done0_cyc, 2);

    // Starvation: req0 keeps re-requesting while req1 waits
    fixed_delay = 0;
    n0 = grant_log.size();
    fork
      do_req(1, 1'b0, 32'h8000, 32'h0, 1'b0, 400);
      begin
        for (int k = 0; k < (GUARD ? 6 : 20); k++)
          do_req(0, 1'b0, 32'h200 + 32'(4 * k), 32'h0, (k < (GUARD ? 5 : 19)), 400);
      end
    join
    if (GUARD) begin
      check("starve_log_len", grant_log.size() >= n0 + MAX_STARVE + 1, 1'b1);
      if (grant_log.size() >= n0 + MAX_STARVE + 1) begin
        for (int i = 0; i < MAX_STARVE; i++) check("starve_req0_grant", grant_log[n0 + i], 0);
        check("starve_req1_grant", grant_log[n0 + MAX_STARVE], 1);
      end
    end else begin
      check("starve_log_len", grant_log.size() >= n0 + 21, 1'b1);
      if (grant_log.size() >= n0 + 21) begin
        for (int i = 0; i < 20; i++) check("nostarve_req0_grant", grant_log[n0 + i], 0);
        check("nostarve_req1_last", grant_log[n0 + 20], 1);
      end
    end

    // Reset during BUSY0 with DM never ready
    fixed_delay = 100;
    @(posedge CLK); #1;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h300;
    @(negedge CLK);
    @(negedge CLK);
    check("midrst_busy_strobe", MemRead_2DM, 1'b1);
    @(posedge CLK); #1;
    RESET = 1'b0;
    req0_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check("midrst_strobes", {MemRead_2DM, MemWrite_2DM}, 2'b00);
    check("midrst_no_done", {req0_done, req1_done}, 2'b00);
    @(posedge CLK); #1;
    RESET = 1'b1;
    last_rd[0] = '0;
    last_rd[1] = '0;
    repeat (3) begin
      @(negedge CLK);
      check("postrst_strobes", {MemRead_2DM, MemWrite_2DM}, 2'b00);
      check("postrst_no_done", {req0_done, req1_done}, 2'b00);
    end
    fixed_delay = 0;
    do_req(0, 1'b0, 32'h304, 32'h0, 1'b0, 10);

    // Randomized traffic on disjoint address ranges
    fixed_delay = -1;
    fork
      begin
        for (int k = 0; k < 30; k++) begin
          repeat ($urandom_range(0, 3)) @(posedge CLK);
          do_req(0, 1'($urandom_range(0, 1)), 32'h100 + 32'(4 * $urandom_range(0, 15)), $urandom, 1'b0, 60);
        end
      end
      begin
        for (int k = 0; k < 30; k++) begin
          repeat ($urandom_range(0, 3)) @(posedge CLK);
          do_req(1, 1'($urandom_range(0, 1)), 32'h8000 + 32'(4 * $urandom_range(0, 15)), $urandom, 1'b0, 60);
        end
      end
    join
    repeat (4) @(negedge CLK);
    check("q0_drained", exp_q0.size(), 0);
    check("q1_drained", exp_q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
